// File: rtl/frame_max_min8.sv
// frame_max_min8: per-frame running maximum, minimum and sample count of an
// 8-bit unsigned stream. The magnitude comparisons use an external 8-bit
// comparator. The block drives the two operands and reads back a one-hot
// result in the same cycle. One comparator therefore serves both the max
// update and the min update, in two consecutive states.
module frame_max_min8 (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iValid,
    input  logic       iFirst,
    input  logic       iLast,
    input  logic [7:0] iData,
    output logic       oReady,
    output logic [7:0] oCmp_a,
    output logic [7:0] oCmp_b,
    input  logic [2:0] iCmp,
    output logic [7:0] oMax,
    output logic [7:0] oMin,
    output logic [7:0] oCount,
    output logic       oDone,
    output logic       oErr
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMP_MAX = 2'd1,
        CMP_MIN = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Comparator result bits, named for readability.
    localparam int CMP_GT = 2;
    localparam int CMP_LT = 0;

    state_t     state_reg, state_next;

    logic       frame_open_reg;   // a frame has been started and not yet closed
    logic [7:0] run_max_reg;
    logic [7:0] run_min_reg;
    logic [7:0] run_count_reg;
    logic [7:0] sample_reg;       // non-first sample waiting for its comparisons
    logic       last_reg;         // that sample also closes the frame

    logic [7:0] out_max_reg;
    logic [7:0] out_min_reg;
    logic [7:0] out_count_reg;
    logic       err_reg;

    // The operands are held in IDLE and DONE. They are registered copies of
    // whatever was last driven, so the comparator inputs never glitch between
    // frames.
    logic [7:0] hold_a_reg;
    logic [7:0] hold_b_reg;
    logic [7:0] cmp_a;
    logic [7:0] cmp_b;

    logic       accept;
    logic [7:0] count_inc;

    assign oReady = (state_reg == IDLE);
    assign accept = iValid & oReady;

    // Counting saturates so that long frames report 255 rather than wrap.
    assign count_inc = (run_count_reg == 8'hFF) ? 8'hFF : run_count_reg + 8'd1;

    // Next-state decode. iFirst/iLast only matter on an accepted sample.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (iFirst) begin
                        state_next = iLast ? DONE : IDLE;
                    end else if (frame_open_reg) begin
                        state_next = CMP_MAX;
                    end
                end
            end
            CMP_MAX: state_next = CMP_MIN;
            CMP_MIN: state_next = last_reg ? DONE : IDLE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Comparator operand selection: the latched sample against the running
    // max, then against the running min. In other states the last pair is held.
    always_comb begin
        cmp_a = hold_a_reg;
        cmp_b = hold_b_reg;
        case (state_reg)
            CMP_MAX: begin
                cmp_a = sample_reg;
                cmp_b = run_max_reg;
            end
            CMP_MIN: begin
                cmp_a = sample_reg;
                cmp_b = run_min_reg;
            end
            default: begin
                cmp_a = hold_a_reg;
                cmp_b = hold_b_reg;
            end
        endcase
    end

    assign oCmp_a = cmp_a;
    assign oCmp_b = cmp_b;

    // State register.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Remember the operands currently driven so they can be held later.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            hold_a_reg <= 8'd0;
            hold_b_reg <= 8'd0;
        end else begin
            hold_a_reg <= cmp_a;
            hold_b_reg <= cmp_b;
        end
    end

    // Running frame state. A frame is opened by an accepted first sample. It
    // is updated by the compare states and closed in DONE. An accepted first
    // sample always restarts, which silently drops any frame already open.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            frame_open_reg <= 1'b0;
            run_max_reg    <= 8'd0;
            run_min_reg    <= 8'd0;
            run_count_reg  <= 8'd0;
            sample_reg     <= 8'd0;
            last_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (iFirst) begin
                            frame_open_reg <= 1'b1;
                            run_max_reg    <= iData;
                            run_min_reg    <= iData;
                            run_count_reg  <= 8'd1;
                        end else if (frame_open_reg) begin
                            sample_reg     <= iData;
                            last_reg       <= iLast;
                            run_count_reg  <= count_inc;
                        end
                    end
                end
                CMP_MAX: begin
                    // Equal values leave the running max as it is.
                    if (iCmp[CMP_GT]) begin
                        run_max_reg <= sample_reg;
                    end
                end
                CMP_MIN: begin
                    if (iCmp[CMP_LT]) begin
                        run_min_reg <= sample_reg;
                    end
                end
                DONE: begin
                    frame_open_reg <= 1'b0;
                end
                default: begin
                    frame_open_reg <= 1'b0;
                end
            endcase
        end
    end

    // Published results. They are loaded while oDone is high and then hold
    // until the next completed frame.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            out_max_reg   <= 8'd0;
            out_min_reg   <= 8'd0;
            out_count_reg <= 8'd0;
        end else if (state_reg == DONE) begin
            out_max_reg   <= run_max_reg;
            out_min_reg   <= run_min_reg;
            out_count_reg <= run_count_reg;
        end
    end

    // Error pulse. It marks a continuation sample that arrived with no frame
    // open; that sample is dropped.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= accept & ~iFirst & ~frame_open_reg;
        end
    end

    assign oMax   = out_max_reg;
    assign oMin   = out_min_reg;
    assign oCount = out_count_reg;
    assign oDone  = (state_reg == DONE);
    assign oErr   = err_reg;

endmodule

// File: tb/tb_frame_max_min8.sv
// Testbench for frame_max_min8: a table of whole-frame vectors with
// hand-computed results, plus sequences for latency, saturation and reset.
module tb_frame_max_min8;

    logic       iClk   = 1'b0;
    logic       iRst_n = 1'b0;
    logic       iValid = 1'b0;
    logic       iFirst = 1'b0;
    logic       iLast  = 1'b0;
    logic [7:0] iData  = 8'd0;
    logic       oReady;
    logic [7:0] oCmp_a;
    logic [7:0] oCmp_b;
    logic [2:0] iCmp;
    logic [7:0] oMax;
    logic [7:0] oMin;
    logic [7:0] oCount;
    logic       oDone;
    logic       oErr;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    frame_max_min8 dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iValid (iValid),
        .iFirst (iFirst),
        .iLast  (iLast),
        .iData  (iData),
        .oReady (oReady),
        .oCmp_a (oCmp_a),
        .oCmp_b (oCmp_b),
        .iCmp   (iCmp),
        .oMax   (oMax),
        .oMin   (oMin),
        .oCount (oCount),
        .oDone  (oDone),
        .oErr   (oErr)
    );

    always #5 iClk = ~iClk;

    // External comparator: same-cycle, one-hot {gt, eq, lt}.
    assign iCmp = {oCmp_a > oCmp_b, oCmp_a == oCmp_b, oCmp_a < oCmp_b};

    // Pulse counters, sampled away from the active edge.
    always @(negedge iClk) begin
        if (oDone === 1'b1) done_cnt <= done_cnt + 1;
        if (oErr === 1'b1)  err_cnt  <= err_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time expired");
        $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        int          n;
        logic [31:0] data;   // sample s in byte s
        logic [3:0]  fst;
        logic [3:0]  lst;
        int          edone;
        int          eerr;
        logic [7:0]  emax;
        logic [7:0]  emin;
        logic [7:0]  ecnt;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge iClk);
    endtask

    // Offer one sample. Wait (bounded) for oReady, and return #1 after the
    // accepting edge.
    task automatic send(input logic [7:0] d, input logic f, input logic l);
        int guard;
        guard = 0;
        @(negedge iClk);
        while (oReady !== 1'b1 && guard < 16) begin
            @(negedge iClk);
            guard++;
        end
        if (oReady !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: oReady=%b required 1", oReady);
        end
        iValid = 1'b1;
        iData  = d;
        iFirst = f;
        iLast  = l;
        @(posedge iClk);
        #1;
        iValid = 1'b0;
        iFirst = 1'b0;
        iLast  = 1'b0;
        iData  = 8'hA5;
    endtask

    initial begin
        int d0;
        int e0;
        vecs[0] = '{"four_sample",   4, 32'hFE017F80, 4'b0001, 4'b1000, 1, 0, 8'hFE, 8'h01, 8'd4};
        vecs[1] = '{"all_equal",     3, 32'h00050505, 4'b0001, 4'b0100, 1, 0, 8'h05, 8'h05, 8'd3};
        vecs[2] = '{"restart",       4, 32'h09073020, 4'b0101, 4'b1000, 1, 0, 8'h09, 8'h07, 8'd2};
        vecs[3] = '{"ascending",     3, 32'h00302010, 4'b0001, 4'b0100, 1, 0, 8'h30, 8'h10, 8'd3};
        vecs[4] = '{"descending",    3, 32'h00115090, 4'b0001, 4'b0100, 1, 0, 8'h90, 8'h11, 8'd3};
        vecs[5] = '{"orphan",        1, 32'h00000033, 4'b0000, 4'b0000, 0, 1, 8'h90, 8'h11, 8'd3};
        vecs[6] = '{"orphan_last",   1, 32'h00000044, 4'b0000, 4'b0001, 0, 1, 8'h90, 8'h11, 8'd3};
        vecs[7] = '{"single",        1, 32'h00000042, 4'b0001, 4'b0001, 1, 0, 8'h42, 8'h42, 8'd1};

        // Reset state
        #3;
        check("rst_max",   oMax,   8'h00);
        check("rst_min",   oMin,   8'h00);
        check("rst_count", oCount, 8'h00);
        check("rst_cmp_a", oCmp_a, 8'h00);
        check("rst_cmp_b", oCmp_b, 8'h00);
        check("rst_done",  oDone,  1'b0);
        check("rst_err",   oErr,   1'b0);
        check("rst_ready", oReady, 1'b1);
        idle(3);
        iRst_n = 1'b1;
        idle(2);

        // Sample without iFirst right after reset: error, nothing published
        d0 = done_cnt; e0 = err_cnt;
        send(8'h10, 1'b0, 1'b0);
        @(negedge iClk);
        check("orphan_err_pulse", oErr, 1'b1);
        idle(4);
        check("orphan_err_cnt",  err_cnt - e0, 1);
        check("orphan_done_cnt", done_cnt - d0, 0);
        check("orphan_max",      oMax, 8'h00);
        check("orphan_count",    oCount, 8'h00);
        $display("txn post_reset_orphan: err=%0d done=%0d", err_cnt - e0, done_cnt - d0);

        // Table-driven frames
        for (int v = 0; v < 8; v++) begin
            d0 = done_cnt; e0 = err_cnt;
            for (int s = 0; s < vecs[v].n; s++)
                send(vecs[v].data[8*s +: 8], vecs[v].fst[s], vecs[v].lst[s]);
            idle(6);
            check({vecs[v].name, "_done"},  done_cnt - d0, vecs[v].edone);
            check({vecs[v].name, "_err"},   err_cnt - e0,  vecs[v].eerr);
            check({vecs[v].name, "_max"},   oMax,   vecs[v].emax);
            check({vecs[v].name, "_min"},   oMin,   vecs[v].emin);
            check({vecs[v].name, "_count"}, oCount, vecs[v].ecnt);
            $display("txn %s: max=%h min=%h count=%0d done=%0d err=%0d",
                     vecs[v].name, oMax, oMin, oCount, done_cnt - d0, err_cnt - e0);
        end

        // Operands held since the last compare (descending frame, min stage: 0x11 vs 0x50)
        check("hold_cmp_a", oCmp_a, 8'h11);
        check("hold_cmp_b", oCmp_b, 8'h50);

        // oReady low exactly 2 cycles after a non-last continuation; oDone 3 cycles after last
        send(8'h05, 1'b1, 1'b0);
        send(8'h06, 1'b0, 1'b0);
        @(negedge iClk); check("rdy_gap1", oReady, 1'b0);
        @(negedge iClk); check("rdy_gap2", oReady, 1'b0);
        @(negedge iClk); check("rdy_gap3", oReady, 1'b1);
        send(8'h07, 1'b0, 1'b1);
        @(negedge iClk); check("last_lat1", oDone, 1'b0);
        @(negedge iClk); check("last_lat2", oDone, 1'b0);
        @(negedge iClk); check("last_lat3", oDone, 1'b1);
        @(negedge iClk); check("last_lat4", oDone, 1'b0);
        check("lat_max",   oMax,   8'h07);
        check("lat_min",   oMin,   8'h05);
        check("lat_count", oCount, 8'd3);
        $display("txn latency_frame: max=%h min=%h count=%0d", oMax, oMin, oCount);

        // Single-sample frame: oDone one cycle after accept, for exactly one cycle
        send(8'h42, 1'b1, 1'b1);
        @(negedge iClk); check("single_lat1", oDone, 1'b1);
        @(negedge iClk); check("single_lat2", oDone, 1'b0);
        check("single_ready", oReady, 1'b1);
        $display("txn single_latency: max=%h", oMax);

        // iFirst/iLast without iValid must not affect an open frame
        send(8'h60, 1'b1, 1'b0);
        @(negedge iClk);
        iFirst = 1'b1; iLast = 1'b1; iData = 8'hEE;
        idle(2);
        iFirst = 1'b0; iLast = 1'b0;
        d0 = done_cnt;
        send(8'h61, 1'b0, 1'b1);
        idle(5);
        check("noacc_done",  done_cnt - d0, 1);
        check("noacc_max",   oMax,   8'h61);
        check("noacc_min",   oMin,   8'h60);
        check("noacc_count", oCount, 8'd2);
        $display("txn unqualified_flags: max=%h min=%h count=%0d", oMax, oMin, oCount);

        // Count saturation: 300 samples i[7:0], i = 0..299
        for (int i = 0; i < 300; i++)
            send(8'(i), i == 0, i == 299);
        idle(5);
        check("sat_max",   oMax,   8'hFF);
        check("sat_min",   oMin,   8'h00);
        check("sat_count", oCount, 8'hFF);
        $display("txn saturate: max=%h min=%h count=%0d", oMax, oMin, oCount);

        // Asynchronous reset during CMP_MAX of frame 0x01,0xFF
        d0 = done_cnt;
        send(8'h01, 1'b1, 1'b0);
        send(8'hFF, 1'b0, 1'b1);
        check("cmpmax_a", oCmp_a, 8'hFF);
        check("cmpmax_b", oCmp_b, 8'h01);
        #2;
        iRst_n = 1'b0;
        #1;
        check("arst_max",   oMax,   8'h00);
        check("arst_min",   oMin,   8'h00);
        check("arst_count", oCount, 8'h00);
        check("arst_cmp_a", oCmp_a, 8'h00);
        check("arst_cmp_b", oCmp_b, 8'h00);
        check("arst_done",  oDone,  1'b0);
        check("arst_ready", oReady, 1'b1);
        iValid = 1'b1; iFirst = 1'b1; iLast = 1'b1; iData = 8'h77;
        idle(2);
        iValid = 1'b0; iFirst = 1'b0; iLast = 1'b0;
        iRst_n = 1'b1;
        idle(5);
        check("arst_no_done", done_cnt - d0, 0);
        check("arst_max_after", oMax, 8'h00);
        e0 = err_cnt;
        send(8'h10, 1'b0, 1'b0);
        idle(4);
        check("arst_orphan_err", err_cnt - e0, 1);
        check("arst_count_after", oCount, 8'h00);
        $display("txn reset_mid_frame: done=%0d err=%0d", done_cnt - d0, err_cnt - e0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
